majority_vote_scheduler: RTL

MAJORITY_VOTE_SCHEDULER -- requirements
Module: majority_vote_scheduler

---
 rtl/vote_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/majority_vote_scheduler.sv | 117 +++++++++++
 3 files changed

// File: rtl/vote_pkg.sv
// Shared types and defaults for the majority-vote scheduler: FSM state
// encoding, default channel/majority/timeout sizes and the tally width.
package vote_pkg;

  localparam int DEF_SIZE     = 9;
  localparam int DEF_MAJORITY = 5;
  localparam int DEF_TIMEOUT  = 64;

  function automatic int tally_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int TALLY_W = tally_width(DEF_SIZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EVAL    = 2'd2,
    DONE    = 2'd3
  } vote_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant over SIZE requesters, starting the search at pointer.
// Purely combinational; no backpressure of its own, the caller masks req.
module rr_arbiter #(
  parameter int SIZE = 9,
  parameter int PW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic [SIZE-1:0] req,
  input  logic [PW-1:0]   pointer,
  output logic [SIZE-1:0] gnt
);

  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < SIZE; k++) begin
      idx = int'(pointer) + k;
      if (idx >= SIZE) idx = idx - SIZE;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/majority_vote_scheduler.sv
// Collects one vote per voter via round-robin grants, then decides tally >= MAJORITY;
// result_valid SIZE+2 cycles after start at best, held until result_ready. Timeout: VOTE_TIMEOUT_EN.
module majority_vote_scheduler
  import vote_pkg::*;
#(
  parameter int SIZE     = DEF_SIZE,
  parameter int MAJORITY = DEF_MAJORITY,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [SIZE-1:0]            vote_valid,
  input  logic [SIZE-1:0]            vote_data,
  output logic [SIZE-1:0]            vote_ready,
  output logic                       result,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic                       busy,
  output logic [$clog2(SIZE+1)-1:0]  tally,
  output logic [SIZE-1:0]            voted
);

  localparam int TW = tally_width(SIZE);
  localparam int PW = (SIZE > 1) ? $clog2(SIZE) : 1;

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_COLLECT = COLLECT;
  localparam logic [1:0] ST_EVAL    = EVAL;
  localparam logic [1:0] ST_DONE    = DONE;

  logic [1:0]      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_nxt, gidx;
  logic [SIZE-1:0] req, gnt, voted_nxt;
  logic            accept, accept_one, timed_out;

  // Only voters that have not yet voted in this ballot may compete.
  assign req        = (state_q == ST_COLLECT) ? (vote_valid & ~voted) : '0;
  assign vote_ready = gnt;
  assign accept     = |gnt;
  assign accept_one = |(gnt & vote_data);
  assign voted_nxt  = voted | gnt;

  rr_arbiter #(.SIZE(SIZE), .PW(PW)) u_arb (
    .req     (req),
    .pointer (ptr_q),
    .gnt     (gnt)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (gnt[i]) gidx = PW'(i);
    end
  end

  assign ptr_nxt = (gidx == PW'(SIZE - 1)) ? '0 : gidx + PW'(1);

`ifdef VOTE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tcnt_q;

  // Fires on the TIMEOUT-th COLLECT cycle; a vote granted in that cycle still lands.
  assign timed_out = (tcnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      tcnt_q <= '0;
    end else if (state_q == ST_COLLECT && !timed_out) begin
      tcnt_q <= tcnt_q + CW'(1);
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_COLLECT;
      // Looking at the post-acceptance mask saves a cycle on the last vote.
      ST_COLLECT: if ((&voted_nxt) || timed_out) state_d = ST_EVAL;
      ST_EVAL:    state_d = ST_DONE;
      ST_DONE:    if (result_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      tally   <= '0;
      voted   <= '0;
      result  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        tally <= '0;
        voted <= '0;
      end else if (accept) begin
        voted <= voted_nxt;
        tally <= tally + TW'(accept_one);
        ptr_q <= ptr_nxt;
      end
      if (state_q == ST_EVAL) begin
        result <= (int'(tally) >= MAJORITY);
      end
    end
  end

  assign result_valid = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE);

endmodule
